// File: rtl/uartwb_host.sv
// Host-side UART-Wishbone bridge initiator: sends one CMD/ADDR/DATA/CHK frame
// over the Tx byte stream, then collects and checks the bridge's reply from Rx.
module uartwb_host #(
  parameter int unsigned ADDR_WID    = 32,
  parameter int unsigned DATA_WID    = 32,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_i,
  input  logic                req_wr_i,
  input  logic [ADDR_WID-1:0] req_addr_i,
  input  logic [DATA_WID-1:0] req_data_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [1:0]          status_o,
  output logic [DATA_WID-1:0] rdata_o,
  output logic                tx_en_o,
  output logic [7:0]          tx_data_o,
  input  logic                tx_ready_i,
  input  logic                rx_valid_i,
  input  logic [7:0]          rx_data_i
);

  localparam logic [4:0]  ADDR_LAST = 5'(ADDR_WID / 8 - 1);
  localparam logic [4:0]  DATA_LAST = 5'(DATA_WID / 8 - 1);
  localparam logic [31:0] TMO       = 32'(TIMEOUT_CYC);

  typedef enum logic [2:0] {
    IDLE, TX_CMD, TX_ADDR, TX_DATA, TX_CHK, RX_CMD, RX_DATA, DONE
  } state_t;

  state_t              state, nxt;
  logic                wr_q;
  logic [ADDR_WID-1:0] addr_sh;
  logic [DATA_WID-1:0] data_sh, hold_q, nxt_hold;
  logic [7:0]          chk_q, cmd;
  logic [4:0]          ctr;
  logic [31:0]         tmo_q;
  logic [1:0]          stat_q, nxt_stat;
  logic                rx_valid_q, rx_evt, rx_phase, tmo_hit, tx_acc;

  assign cmd      = {7'b0, wr_q};
  assign rx_evt   = rx_valid_i & ~rx_valid_q;
  assign rx_phase = (state == RX_CMD) || (state == RX_DATA);
  // A byte arriving on the expiry cycle takes precedence over the timeout.
  assign tmo_hit  = (TMO != '0) && rx_phase && !rx_evt && (tmo_q == TMO - 32'd1);
  assign tx_acc   = tx_en_o & tx_ready_i;
  assign busy_o   = (state != IDLE);
  assign done_o   = (state == DONE);

  always_comb begin
    nxt       = state;
    nxt_stat  = stat_q;
    nxt_hold  = hold_q;
    tx_en_o   = 1'b0;
    tx_data_o = '0;
    case (state)
      IDLE: if (req_i) nxt = TX_CMD;
      TX_CMD: begin
        tx_en_o   = 1'b1;
        tx_data_o = cmd;
        if (tx_ready_i) nxt = TX_ADDR;
      end
      TX_ADDR: begin
        tx_en_o   = 1'b1;
        tx_data_o = addr_sh[ADDR_WID-1 -: 8];
        if (tx_ready_i && ctr == ADDR_LAST) nxt = TX_DATA;
      end
      TX_DATA: begin
        tx_en_o   = 1'b1;
        tx_data_o = data_sh[DATA_WID-1 -: 8];
        if (tx_ready_i && ctr == DATA_LAST) nxt = TX_CHK;
      end
      TX_CHK: begin
        tx_en_o   = 1'b1;
        tx_data_o = chk_q;
        if (tx_ready_i) nxt = RX_CMD;
      end
      RX_CMD: begin
        // Reads always collect the data bytes, even after a checksum-error echo.
        if (rx_evt) begin
          if (rx_data_i == 8'hFF)   nxt_stat = 2'b01;
          else if (rx_data_i == cmd) nxt_stat = 2'b00;
          else                      nxt_stat = 2'b11;
          nxt = wr_q ? DONE : RX_DATA;
        end else if (tmo_hit) begin
          nxt_stat = 2'b10;
          nxt      = DONE;
        end
      end
      RX_DATA: begin
        if (rx_evt) begin
          nxt_hold = (hold_q << 8) | DATA_WID'(rx_data_i);
          if (ctr == DATA_LAST) nxt = DONE;
        end else if (tmo_hit) begin
          nxt_stat = 2'b10;
          nxt      = DONE;
        end
      end
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      wr_q       <= 1'b0;
      addr_sh    <= '0;
      data_sh    <= '0;
      hold_q     <= '0;
      chk_q      <= '0;
      ctr        <= '0;
      tmo_q      <= '0;
      stat_q     <= '0;
      rx_valid_q <= 1'b1;
      status_o   <= '0;
      rdata_o    <= '0;
    end else begin
      state      <= nxt;
      rx_valid_q <= rx_valid_i;
      stat_q     <= nxt_stat;
      hold_q     <= nxt_hold;
      if (state == IDLE && req_i) begin
        wr_q    <= req_wr_i;
        addr_sh <= req_addr_i;
        data_sh <= req_data_i;
        chk_q   <= 8'hFF;
      end
      if (tx_acc && state != TX_CHK) chk_q <= chk_q ^ tx_data_o;
      if (tx_acc && state == TX_ADDR) addr_sh <= addr_sh << 8;
      if (tx_acc && state == TX_DATA) data_sh <= data_sh << 8;
      if (nxt != state)
        ctr <= '0;
      else if (tx_acc || (state == RX_DATA && rx_evt))
        ctr <= ctr + 5'd1;
      if (!rx_phase || rx_evt) tmo_q <= '0;
      else                     tmo_q <= tmo_q + 32'd1;
      if (nxt == DONE && state != DONE) begin
        status_o <= nxt_stat;
        if (!wr_q && nxt_stat == 2'b00) rdata_o <= nxt_hold;
      end
    end
  end

endmodule

// File: tb/tb_uartwb_host.sv
// Bench for uartwb_host: table of request/reply vectors checked through a Tx byte
// scoreboard and a result scoreboard, plus reset-abort and req-at-done sequences.
module tb_uartwb_host;
  localparam int unsigned TMO = 100;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_i = 1'b0, req_wr_i = 1'b0;
  logic [31:0] req_addr_i = '0, req_data_i = '0;
  logic        busy_o, done_o, tx_en_o;
  logic [1:0]  status_o;
  logic [31:0] rdata_o;
  logic [7:0]  tx_data_o;
  logic        tx_ready_i = 1'b1;
  logic        rx_valid_i = 1'b1;
  logic [7:0]  rx_data_i = '0;

  uartwb_host #(.ADDR_WID(32), .DATA_WID(32), .TIMEOUT_CYC(TMO)) dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .req_wr_i(req_wr_i),
    .req_addr_i(req_addr_i), .req_data_i(req_data_i), .busy_o(busy_o),
    .done_o(done_o), .status_o(status_o), .rdata_o(rdata_o), .tx_en_o(tx_en_o),
    .tx_data_o(tx_data_o), .tx_ready_i(tx_ready_i), .rx_valid_i(rx_valid_i),
    .rx_data_i(rx_data_i)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [39:0] rep;     // reply bytes, first byte in the top octet
    int          nrep;
    bit          slow;    // tx_ready_i high one cycle in three
    bit          stray;   // Rx strobes while the frame is going out
    logic [1:0]  st;
    logic [31:0] rd;
  } vec_t;

  vec_t        vecs[10];
  logic [7:0]  exp_tx[$];
  logic [33:0] exp_res[$];
  logic [33:0] r_done;
  int          n_cmp = 0, n_bad = 0, done_cnt = 0, ph = 0;
  bit          slow = 1'b0, stray_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: actual event/expiry, required none", name);
  endtask

  function automatic void push_frame(input logic wr, input logic [31:0] a, input logic [31:0] d);
    logic [71:0] f = {7'b0, wr, a, d};
    logic [7:0]  c = 8'hFF;
    logic [7:0]  b;
    for (int i = 0; i < 9; i++) begin
      b = f[71-8*i -: 8];
      exp_tx.push_back(b);
      c = c ^ b;
    end
    exp_tx.push_back(c);
  endfunction

  always @(negedge clk) begin
    if (rst_i === 1'b0 && tx_en_o === 1'b1 && tx_ready_i === 1'b1) begin
      if (exp_tx.size() == 0) fail("tx_extra_byte");
      else check("tx_byte", {24'b0, tx_data_o}, {24'b0, exp_tx.pop_front()});
    end
  end

  always @(negedge clk) begin
    if (done_o === 1'b1) begin
      done_cnt++;
      if (exp_res.size() == 0) fail("done_unexpected");
      else begin
        r_done = exp_res.pop_front();
        check("status", {30'b0, status_o}, {30'b0, r_done[33:32]});
        check("rdata", rdata_o, r_done[31:0]);
      end
    end
  end

  initial forever begin
    @(posedge clk); #1;
    if (slow) begin
      tx_ready_i = (ph == 0);
      ph = (ph + 1) % 3;
    end else tx_ready_i = 1'b1;
  end

  // Only strobe while at least two frame bytes remain, so no stray edge can land in RX_CMD.
  initial forever begin
    @(posedge clk); #1;
    if (stray_en && exp_tx.size() >= 2 && !rx_valid_i) begin
      rx_data_i  = 8'h01;
      rx_valid_i = 1'b1;
      @(posedge clk); #1;
      rx_valid_i = 1'b0;
      @(posedge clk);
    end
  end

  task automatic run_txn(input vec_t v, input bit req_at_done);
    int         n;
    logic [7:0] b;
    slow     = v.slow;
    stray_en = v.stray;
    push_frame(v.wr, v.addr, v.data);
    exp_res.push_back({v.st, v.rd});
    @(posedge clk); #1;
    req_i = 1'b1; req_wr_i = v.wr; req_addr_i = v.addr; req_data_i = v.data;
    @(posedge clk); #1;
    check("busy_after_accept", {31'b0, busy_o}, 32'd1);
    req_wr_i = ~v.wr; req_addr_i = ~v.addr; req_data_i = ~v.data;
    repeat (3) @(posedge clk);
    #1 req_i = 1'b0;
    n = 0;
    while (exp_tx.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (exp_tx.size() != 0) begin
      fail("tx_frame_timeout");
      exp_tx.delete();
    end
    stray_en   = 1'b0;
    rx_valid_i = 1'b0;
    for (int i = 0; i < v.nrep; i++) begin
      b = 8'(v.rep >> (8 * (4 - i)));
      @(posedge clk);
      @(posedge clk); #1;
      rx_data_i  = b;
      rx_valid_i = 1'b1;
      @(posedge clk); #1;
      rx_valid_i = 1'b0;
    end
    // n counts negedges from the edge that captured the last reply byte.
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done_o !== 1'b1 && n < 400);
    if (done_o !== 1'b1) fail("done_timeout");
    else if (v.st == 2'b10) check("timeout_latency", 32'(n), 32'(TMO + 1));
    if (req_at_done) begin
      req_i = 1'b1; req_wr_i = 1'b1; req_addr_i = 32'h0000_0BAD; req_data_i = '1;
    end
    @(posedge clk); #1;
    req_i = 1'b0;
    check("busy_after_done", {31'b0, busy_o}, 32'd0);
    repeat (3) @(posedge clk);
    #1 check("idle_no_restart", {30'b0, tx_en_o, busy_o}, 32'd0);
    if (exp_res.size() != 0) begin
      fail("result_missing");
      exp_res.delete();
    end
  endtask

  initial begin
    int   d0, n;
    vec_t v;
    vecs[0] = '{1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 40'h01_0000_0000, 1, 1'b0, 1'b0, 2'b00, 32'h0};
    vecs[1] = '{1'b0, 32'h0000_0004, 32'h0,         40'h00_1234_5678, 5, 1'b0, 1'b0, 2'b00, 32'h1234_5678};
    vecs[2] = '{1'b0, 32'h0000_0008, 32'h55,        40'hFF_AABB_CCDD, 5, 1'b0, 1'b0, 2'b01, 32'h1234_5678};
    vecs[3] = '{1'b1, 32'h0000_0020, 32'h1,         40'hFF_0000_0000, 1, 1'b0, 1'b0, 2'b01, 32'h1234_5678};
    vecs[4] = '{1'b1, 32'h0000_0030, 32'h2,         40'h00_0000_0000, 1, 1'b0, 1'b0, 2'b11, 32'h1234_5678};
    vecs[5] = '{1'b0, 32'h0000_0040, 32'h0,         40'h01_1122_3344, 5, 1'b0, 1'b0, 2'b11, 32'h1234_5678};
    vecs[6] = '{1'b0, 32'hABCD_0000, 32'h0,         40'h00_CAFE_BABE, 5, 1'b0, 1'b0, 2'b00, 32'hCAFE_BABE};
    vecs[7] = '{1'b0, 32'h0000_0044, 32'h0,         40'h00_1234_0000, 3, 1'b0, 1'b0, 2'b10, 32'hCAFE_BABE};
    vecs[8] = '{1'b1, 32'h0000_0050, 32'h0000_A5A5, 40'hFF_0000_0000, 1, 1'b1, 1'b1, 2'b01, 32'hCAFE_BABE};
    vecs[9] = '{1'b0, 32'h0000_0060, 32'h0,         40'h00_0102_0304, 5, 1'b1, 1'b1, 2'b00, 32'h0102_0304};

    #2;
    check("rst_busy", {31'b0, busy_o}, 32'd0);
    check("rst_done", {31'b0, done_o}, 32'd0);
    check("rst_status", {30'b0, status_o}, 32'd0);
    check("rst_rdata", rdata_o, 32'd0);
    check("rst_tx", {23'b0, tx_en_o, tx_data_o}, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rx_valid_i = 1'b0;
    check("strobe_at_reset_no_done", 32'(done_cnt), 32'd0);

    for (int k = 0; k < 10; k++) run_txn(vecs[k], 1'b0);

    // Abort a write partway through its data bytes with the Rx strobe held high.
    slow = 1'b0;
    push_frame(1'b1, 32'h0000_0070, 32'h1122_3344);
    @(posedge clk); #1;
    req_i = 1'b1; req_wr_i = 1'b1; req_addr_i = 32'h0000_0070; req_data_i = 32'h1122_3344;
    @(posedge clk); #1;
    req_i = 1'b0;
    n = 0;
    while (exp_tx.size() > 3 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    rst_i = 1'b1; rx_valid_i = 1'b1; rx_data_i = 8'h01;
    #1;
    check("abort_tx_en", {31'b0, tx_en_o}, 32'd0);
    check("abort_busy", {31'b0, busy_o}, 32'd0);
    check("abort_rdata", rdata_o, 32'd0);
    exp_tx.delete();
    d0 = done_cnt;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("abort_no_done", 32'(done_cnt), 32'(d0));
    check("abort_idle", {30'b0, tx_en_o, busy_o}, 32'd0);

    v = '{1'b1, 32'h0000_0070, 32'h1122_3344, 40'h01_0000_0000, 1, 1'b0, 1'b0, 2'b00, 32'h0};
    run_txn(v, 1'b1);
    check("post_abort_one_done", 32'(done_cnt), 32'(d0 + 1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual still running, required finished");
    $fatal(1);
  end

endmodule
